// File: rtl/circuito_gravacao.sv
// Key-press recorder: stores each press of chaves into a 16x4 RAM.
// Control FSM walks register -> write -> increment -> wait-for-release.

// Hex digit to active-low 7-segment pattern (gfedcba).
module hexa7seg (
    input  logic [3:0] hexa,
    output logic [6:0] display
);

    // Pure lookup; every 4-bit code has a glyph.
    always_comb begin
        display = 7'b1111111;
        case (hexa)
            4'h0: display = 7'b1000000;
            4'h1: display = 7'b1111001;
            4'h2: display = 7'b0100100;
            4'h3: display = 7'b0110000;
            4'h4: display = 7'b0011001;
            4'h5: display = 7'b0010010;
            4'h6: display = 7'b0000010;
            4'h7: display = 7'b1111000;
            4'h8: display = 7'b0000000;
            4'h9: display = 7'b0010000;
            4'hA: display = 7'b0001000;
            4'hB: display = 7'b0000011;
            4'hC: display = 7'b1000110;
            4'hD: display = 7'b0100001;
            4'hE: display = 7'b0000110;
            4'hF: display = 7'b0001110;
            default: display = 7'b1111111;
        endcase
    end

endmodule

module circuito_gravacao #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       pronto,
    output logic       db_escrita,
    output logic       db_iniciar,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_jogada,
    output logic [6:0] db_chaves,
    output logic [6:0] db_estado
);

    typedef enum logic [3:0] {
        inicial       = 4'h0,
        preparacao    = 4'h1,
        espera        = 4'h2,
        registra      = 4'h3,
        grava         = 4'h4,
        proximo       = 4'h5,
        aguarda_solta = 4'h6,
        fim           = 4'hF
    } state_t;

    localparam int DEPTH = 2 ** ADDR_W;

    state_t              estado;
    state_t              proximo_estado;
    logic [ADDR_W-1:0]   contagem;
    logic [DATA_W-1:0]   jogada;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   leitura;
    logic [3:0]          contagem_ext;
    logic [3:0]          estado_code;
    logic                fim_c;
    logic                tem_jogada;
    logic                zera_c;
    logic                zera_r;
    logic                registra_r;
    logic                conta_c;
    logic                escrita;

    assign fim_c      = (contagem == ADDR_W'(DEPTH - 1));
    assign tem_jogada = (chaves != 4'h0);

    // State register; reset returns to inicial.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= inicial;
        else       estado <= proximo_estado;
    end

    // Next-state and Moore control outputs.
    always_comb begin
        proximo_estado = inicial;
        zera_c         = 1'b0;
        zera_r         = 1'b0;
        registra_r     = 1'b0;
        conta_c        = 1'b0;
        escrita        = 1'b0;
        pronto         = 1'b0;
        case (estado)
            inicial: begin
                proximo_estado = iniciar ? preparacao : inicial;
            end
            preparacao: begin
                zera_c         = 1'b1;
                zera_r         = 1'b1;
                proximo_estado = espera;
            end
            espera: begin
                proximo_estado = tem_jogada ? registra : espera;
            end
            registra: begin
                registra_r     = 1'b1;
                proximo_estado = grava;
            end
            grava: begin
                escrita        = 1'b1;
                proximo_estado = fim_c ? fim : proximo;
            end
            proximo: begin
                conta_c        = 1'b1;
                proximo_estado = aguarda_solta;
            end
            aguarda_solta: begin
                proximo_estado = tem_jogada ? aguarda_solta : espera;
            end
            fim: begin
                pronto         = 1'b1;
                proximo_estado = iniciar ? preparacao : fim;
            end
            default: begin
                proximo_estado = inicial;
            end
        endcase
    end

    // Address counter; never wraps since the last entry skips proximo.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)        contagem <= '0;
        else if (zera_c)  contagem <= '0;
        else if (conta_c) contagem <= contagem + 1'b1;
    end

    // Data register holding the press captured in registra.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)           jogada <= '0;
        else if (zera_r)     jogada <= '0;
        else if (registra_r) jogada <= DATA_W'(chaves);
    end

    // Register-file RAM; cleared only by reset, not by preparacao.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (escrita) begin
            mem[contagem] <= jogada;
        end
    end

    // Asynchronous read of the current address for the debug display.
    always_comb begin
        leitura = mem[contagem];
    end

    // Counter value zero-extended to a single hex digit.
    always_comb begin
        contagem_ext                = 4'h0;
        contagem_ext[ADDR_W-1:0]    = contagem;
    end

    assign estado_code = estado;
    assign db_escrita  = escrita;
    assign db_iniciar  = iniciar;

    hexa7seg u_hex_contagem (.hexa(contagem_ext),   .display(db_contagem));
    hexa7seg u_hex_memoria  (.hexa(4'(leitura)),    .display(db_memoria));
    hexa7seg u_hex_jogada   (.hexa(4'(jogada)),     .display(db_jogada));
    hexa7seg u_hex_chaves   (.hexa(chaves),         .display(db_chaves));
    hexa7seg u_hex_estado   (.hexa(estado_code),    .display(db_estado));

endmodule

// File: tb/tb_circuito_gravacao.sv
// Scoreboard bench for circuito_gravacao: presses push expected RAM words,
// a monitor pops and compares on every RAM write strobe.

module tb_circuito_gravacao;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [3:0] chaves;
    logic       pronto;
    logic       db_escrita;
    logic       db_iniciar;
    logic [6:0] db_contagem;
    logic [6:0] db_memoria;
    logic [6:0] db_jogada;
    logic [6:0] db_chaves;
    logic [6:0] db_estado;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;
    logic [3:0] exp_q [$];

    circuito_gravacao #(.ADDR_W(4), .DATA_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .chaves      (chaves),
        .pronto      (pronto),
        .db_escrita  (db_escrita),
        .db_iniciar  (db_iniciar),
        .db_contagem (db_contagem),
        .db_memoria  (db_memoria),
        .db_jogada   (db_jogada),
        .db_chaves   (db_chaves),
        .db_estado   (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string name, input logic [6:0] act,
                         input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_state(input logic [3:0] code, input string name);
        int n = 0;
        while (db_estado !== seg(code) && n < 40) begin
            @(negedge clock);
            n++;
        end
        check(name, db_estado, seg(code));
    endtask

    // Issue iniciar for one cycle and land in espera.
    task automatic start();
        @(negedge clock);
        iniciar = 1'b1;
        #1 check("db_iniciar", 7'(db_iniciar), 7'd1);
        @(negedge clock);
        check("state_prep", db_estado, seg(4'h1));
        check("pronto_prep", 7'(pronto), 7'd0);
        iniciar = 1'b0;
        wait_state(4'h2, "reach_espera");
    endtask

    // One press: old is the RAM word expected at the current address.
    task automatic press(input logic [3:0] v, input logic [3:0] old,
                         input int hold, input logic [3:0] after);
        int n = 0;
        wait_state(4'h2, "espera_before_press");
        check("mem_before_write", db_memoria, seg(old));
        chaves = v;
        exp_q.push_back(v);
        while (db_estado !== seg(4'h6) && db_estado !== seg(4'hF) && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("state_after_press", db_estado, seg(after));
        if (hold > 0) begin
            step(hold);
            check("state_held", db_estado, seg(4'h6));
        end
        chaves = 4'h0;
        step(1);
    endtask

    // Monitor: every grava cycle must match the oldest expected word.
    initial begin
        logic       esc;
        logic [3:0] e;
        forever begin
            @(negedge clock);
            esc = db_escrita;
            @(posedge clock);
            #1;
            if (esc) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%h expected=none", db_jogada);
                end else begin
                    e = exp_q.pop_front();
                    check("mem_written", db_memoria, seg(e));
                    check("jogada_reg", db_jogada, seg(e));
                end
                check("escrita_width", 7'(db_escrita), 7'd0);
            end
        end
    end

    initial begin
        int w0;
        logic [3:0] vals [16];
        reset   = 1'b1;
        iniciar = 1'b0;
        chaves  = 4'h0;
        step(2);
        check("rst_state", db_estado, seg(4'h0));
        check("rst_contagem", db_contagem, seg(4'h0));
        check("rst_memoria", db_memoria, seg(4'h0));
        check("rst_jogada", db_jogada, seg(4'h0));
        check("rst_pronto", 7'(pronto), 7'd0);
        check("rst_escrita", 7'(db_escrita), 7'd0);
        reset = 1'b0;
        step(3);
        check("idle_state", db_estado, seg(4'h0));

        // Three writes, then reset mid-run.
        start();
        press(4'h1, 4'h0, 0, 4'h6);
        press(4'h2, 4'h0, 0, 4'h6);
        press(4'h3, 4'h0, 0, 4'h6);
        wait_state(4'h2, "espera_before_reset");
        check("count_before_reset", db_contagem, seg(4'h3));
        reset = 1'b1;
        #1;
        check("midrst_state", db_estado, seg(4'h0));
        check("midrst_contagem", db_contagem, seg(4'h0));
        check("midrst_memoria", db_memoria, seg(4'h0));
        check("midrst_pronto", 7'(pronto), 7'd0);
        @(negedge clock);
        reset = 1'b0;
        w0 = n_writes;
        chaves = 4'h8;
        check("db_chaves", db_chaves, seg(4'h8));
        step(10);
        check("no_write_after_reset", 7'(n_writes - w0), 7'd0);
        check("stay_inicial", db_estado, seg(4'h0));
        chaves = 4'h0;
        step(1);

        // Basic record; zero olds prove reset cleared RAM[0..2].
        start();
        w0 = n_writes;
        press(4'h1, 4'h0, 0, 4'h6);
        press(4'h2, 4'h0, 0, 4'h6);
        press(4'h4, 4'h0, 0, 4'h6);
        press(4'h8, 4'h0, 0, 4'h6);
        wait_state(4'h2, "espera_after_basic");
        check("basic_writes", 7'(n_writes - w0), 7'd4);
        check("basic_contagem", db_contagem, seg(4'h4));

        // Full sequence from a clean RAM: 1..F then 1.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        start();
        for (int i = 0; i < 16; i++) vals[i] = 4'(i + 1);
        vals[15] = 4'h1;
        w0 = n_writes;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                wait_state(4'h2, "espera_ign");
                iniciar = 1'b1;
                @(negedge clock);
                iniciar = 1'b0;
                check("iniciar_ignored", db_estado, seg(4'h2));
                check("count_mid", db_contagem, seg(4'h3));
            end
            press(vals[i], 4'h0, (i == 1) ? 20 : 0,
                  (i == 15) ? 4'hF : 4'h6);
        end
        check("full_writes", 7'(n_writes - w0), 7'd16);
        check("full_pronto", 7'(pronto), 7'd1);
        check("full_contagem", db_contagem, seg(4'hF));
        check("full_mem15", db_memoria, seg(4'h1));
        w0 = n_writes;
        chaves = 4'h7;
        step(6);
        chaves = 4'h0;
        step(2);
        check("fim_no_write", 7'(n_writes - w0), 7'd0);
        check("fim_stay", db_estado, seg(4'hF));

        // Restart overwrites from 0; later words keep old values.
        start();
        press(4'h5, 4'h1, 0, 4'h6);
        press(4'h9, 4'h2, 0, 4'h6);
        wait_state(4'h2, "espera_restart");
        check("restart_mem2", db_memoria, seg(4'h3));
        check("restart_contagem", db_contagem, seg(4'h2));

        step(3);
        check("queue_drained", 7'(exp_q.size()), 7'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
